// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width common to master and slave, and RX FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received SPI bytes.
module spi_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty; indexing uses the low AW bits.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign valid   = ~empty;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronises sclk/mosi/frame, deserialises MSB-first words into a FWFT FIFO.
// Optional dropped-byte counter output ovr_count enabled by defining SPI_RX_OVR_CNT_EN.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_WORD_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          frame,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          ovr_clear,
`ifdef SPI_RX_OVR_CNT_EN
    output logic [7:0]                    ovr_count,
`endif
    output logic                          frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] frame_sync;
    logic                   sclk_q;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   frame_s;
    logic                   rise;

    rx_state_t              state;
    logic [DATA_W-1:0]      sr;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   drop;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign frame_s = frame_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_q;

    assign push = (state == PUSH);
    assign pop  = out_valid & out_ready;
    // A full FIFO still takes the byte when the consumer frees a slot in the same cycle.
    assign drop = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            frame_sync <= '0;
            sclk_q     <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            frame_sync <= {frame_sync[SYNC_STAGES-2:0], frame};
            sclk_q     <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_s) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // Frame drop takes priority over a coincident sclk rise.
                    if (!frame_s) begin
                        frame_err <= (bit_cnt != '0);
                        state     <= IDLE;
                    end else if (rise) begin
                        sr      <= {sr[DATA_W-2:0], mosi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    bit_cnt <= '0;
                    state   <= frame_s ? SHIFT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (ovr_clear) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

`ifdef SPI_RX_OVR_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_count <= '0;
        end else if (ovr_clear) begin
            ovr_count <= '0;
        end else if (drop && ovr_count != 8'hFF) begin
            ovr_count <= ovr_count + 8'd1;
        end
    end
`endif

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (sr),
        .pop   (pop),
        .rdata (out_data),
        .valid (out_valid),
        .full  (full),
        .level (level)
    );

endmodule
